occupancy_tracker: RTL and testbench
====================================

OCCUPANCY_TRACKER -- requirements
Module: occupancy_tracker

Interface
REQ-001 SHALL have parameters (name, default, meaning): DISP_W, `DISPATCH_WIDTH, dispatch lanes; ISS_W, `ISSUE_WIDTH, issue lanes; CMT_W, `COMMIT_WIDTH, commit lanes.
REQ-002 SHALL have port clk, input, 1, sole clock; all state is rising-edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port dispatchFire_i, input, 1, dispatch bundle accepted this cycle (renameReady & backEndReady).
REQ-005 SHALL have port laneValid_i, input, DISP_W, per-lane valid instruction in the accepted bundle.
REQ-006 SHALL have ports laneIsLoad_i and laneIsStore_i, input, DISP_W, per-lane load or store flag.
REQ-007 SHALL have port iqIssued_i, input, ISS_W, per-lane issue-queue entry freed this cycle.
REQ-008 SHALL have port alCommit_i, input, CMT_W, per-lane active-list entry committed.
REQ-009 SHALL have ports ldCommit_i and stCommit_i, input, CMT_W, per-lane committed load or store.
REQ-010 SHALL have port stRetire_i, input, 1, one committed store drained to cache.
REQ-011 SHALL have port flush_i, input, 1, recoverFlag | exceptionFlag | reconfigureCore.
REQ-012 SHALL have ports issueQueueCnt_o [`SIZE_ISSUEQ_LOG:0], activeListCnt_o [`SIZE_ACTIVELIST_LOG:0], loadQueueCnt_o and storeQueueCnt_o [`SIZE_LSQ_LOG:0], outputs, registered occupancies.
REQ-013 SHALL have port occError_o, output, 1, sticky overflow/underflow flag.

Function
REQ-014 Dispatch increments SHALL be popcounts gated by dispatchFire_i: IQ/AL += popcount(laneValid_i); LQ += popcount(laneValid_i & laneIsLoad_i); SQ += popcount(laneValid_i & laneIsStore_i).
REQ-015 Frees SHALL be popcounts: IQ -= popcount(iqIssued_i); AL -= popcount(alCommit_i); LQ -= popcount(ldCommit_i); SQ -= stRetire_i.
REQ-016 Internal stCommitted counter SHALL add popcount(stCommit_i) and subtract stRetire_i each cycle.
REQ-017 Increments and decrements in one cycle SHALL combine into one next value; latency is 1 cycle from input to output.
REQ-018 Next values SHALL be computed signed, one bit wider than the count.
REQ-019 Next value > structure size SHALL clamp to size and set occError_o.
REQ-020 Next value < 0 SHALL clamp to 0 and set occError_o.
REQ-021 On flush_i, IQ, AL and LQ SHALL become 0, and dispatch, issue and commit inputs that cycle SHALL be ignored (flush wins).
REQ-022 On flush_i, SQ SHALL become stCommitted next value (including same-cycle stCommit_i/stRetire_i); stCommitted is not cleared.
REQ-023 stCommitted SHALL never exceed SQ; a violation sets occError_o and clamps stCommitted to SQ.
REQ-024 occError_o SHALL remain set until reset.
REQ-025 stRetire_i with stCommitted == 0 SHALL be an underflow under REQ-020.

Reset
REQ-026 reset low SHALL asynchronously force all counts, stCommitted and occError_o to 0.
REQ-027 Reset deasserting mid-operation SHALL resume counting from 0 on the next clk edge; no inputs are sampled while reset is low.

Structure
REQ-028 SIZE_* / *_LOG widths and lane counts SHALL come from the shared configuration header; no new package types.
REQ-029 One parameterized sub-module occ_counter SHALL implement a single clamped up/down counter (inc, dec, flush, flushValue, error) and be instantiated five times.
REQ-030 Popcounts SHALL be combinational functions local to the block.

Verification (DISP_W=4, ISS_W=4, CMT_W=4, AL=128, IQ=32, LSQ=32)
REQ-031 Reset low, then release -> all counts 0 and occError_o 0 on the first cycle.
REQ-032 Three dispatches, laneValid=1111 with 2 loads and 1 store, then iqIssued=0011 -> IQ=10, AL=12, LQ=6, SQ=3.
REQ-033 SQ=5, stCommit=0011 and flush in the same cycle -> IQ=AL=LQ=0, SQ=2; next stRetire -> SQ=1.
REQ-034 IQ=30, dispatch 1111 with iqIssued=0001 -> IQ=32 clamped, occError_o=1 and stays 1.
REQ-035 AL=2, alCommit=0111 -> AL=0, occError_o=1.
REQ-036 Reset asserted asynchronously between edges with counts nonzero -> outputs 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/occupancy_tracker_pkg.sv
// Shared core configuration for the occupancy tracker: lane counts and
// structure sizes (with their log2 widths) used across the back end.
package occupancy_tracker_pkg;

  localparam int DISPATCH_WIDTH = 4;
  localparam int ISSUE_WIDTH    = 4;
  localparam int COMMIT_WIDTH   = 4;

  localparam int SIZE_ACTIVELIST     = 128;
  localparam int SIZE_ACTIVELIST_LOG = 7;
  localparam int SIZE_ISSUEQ         = 32;
  localparam int SIZE_ISSUEQ_LOG     = 5;
  localparam int SIZE_LSQ            = 32;
  localparam int SIZE_LSQ_LOG        = 5;

endpackage

// File: rtl/occupancy_tracker_counter.sv
// Single clamped up/down occupancy counter. The increment and decrement of a
// cycle fold into one signed next value that saturates to [0, limit].
module occ_counter #(
  parameter int CNT_W = 6,
  parameter int INC_W = 3,
  parameter int DEC_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [INC_W-1:0] inc,
  input  logic [DEC_W-1:0] dec,
  input  logic [CNT_W-1:0] limit,
  input  logic             flush,
  input  logic [CNT_W-1:0] flushValue,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] holdNext,
  output logic [CNT_W-1:0] nextCount,
  output logic             error
);

  localparam int SW = CNT_W + 1;

  logic signed [SW-1:0] cntExt;
  logic signed [SW-1:0] incExt;
  logic signed [SW-1:0] decExt;
  logic signed [SW-1:0] limExt;
  logic signed [SW-1:0] sum;
  logic                 under;
  logic                 over;

  assign cntExt = SW'(count);
  assign incExt = SW'(inc);
  assign decExt = SW'(dec);
  assign limExt = SW'(limit);
  assign sum    = cntExt + incExt - decExt;

  assign under = sum[SW-1];
  assign over  = !under && (sum > limExt);

  // holdNext ignores flush so a neighbour counter can use it as a limit
  // without forming a combinational path through flushValue.
  assign holdNext  = under ? '0 : (over ? limit : sum[CNT_W-1:0]);
  assign nextCount = flush ? flushValue : holdNext;
  assign error     = !flush && (under || over);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else begin
      count <= nextCount;
    end
  end

endmodule

// File: rtl/occupancy_tracker.sv
// Back-end occupancy tracker: registered issue queue, active list, load and
// store queue counts, plus a sticky flag for any overflow/underflow.
module occupancy_tracker
  import occupancy_tracker_pkg::*;
#(
  parameter int DISP_W = DISPATCH_WIDTH,
  parameter int ISS_W  = ISSUE_WIDTH,
  parameter int CMT_W  = COMMIT_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         dispatchFire_i,
  input  logic [DISP_W-1:0]            laneValid_i,
  input  logic [DISP_W-1:0]            laneIsLoad_i,
  input  logic [DISP_W-1:0]            laneIsStore_i,
  input  logic [ISS_W-1:0]             iqIssued_i,
  input  logic [CMT_W-1:0]             alCommit_i,
  input  logic [CMT_W-1:0]             ldCommit_i,
  input  logic [CMT_W-1:0]             stCommit_i,
  input  logic                         stRetire_i,
  input  logic                         flush_i,
  output logic [SIZE_ISSUEQ_LOG:0]     issueQueueCnt_o,
  output logic [SIZE_ACTIVELIST_LOG:0] activeListCnt_o,
  output logic [SIZE_LSQ_LOG:0]        loadQueueCnt_o,
  output logic [SIZE_LSQ_LOG:0]        storeQueueCnt_o,
  output logic                         occError_o
);

  localparam int DISP_CW = $clog2(DISP_W + 1);
  localparam int ISS_CW  = $clog2(ISS_W + 1);
  localparam int CMT_CW  = $clog2(CMT_W + 1);
  localparam int IQ_W    = SIZE_ISSUEQ_LOG + 1;
  localparam int AL_W    = SIZE_ACTIVELIST_LOG + 1;
  localparam int LSQ_W   = SIZE_LSQ_LOG + 1;

  localparam logic [IQ_W-1:0]  IQ_MAX  = IQ_W'(SIZE_ISSUEQ);
  localparam logic [AL_W-1:0]  AL_MAX  = AL_W'(SIZE_ACTIVELIST);
  localparam logic [LSQ_W-1:0] LSQ_MAX = LSQ_W'(SIZE_LSQ);

  function automatic logic [DISP_CW-1:0] popDisp(input logic [DISP_W-1:0] v);
    popDisp = '0;
    for (int i = 0; i < DISP_W; i++) popDisp = popDisp + DISP_CW'(v[i]);
  endfunction

  function automatic logic [ISS_CW-1:0] popIss(input logic [ISS_W-1:0] v);
    popIss = '0;
    for (int i = 0; i < ISS_W; i++) popIss = popIss + ISS_CW'(v[i]);
  endfunction

  function automatic logic [CMT_CW-1:0] popCmt(input logic [CMT_W-1:0] v);
    popCmt = '0;
    for (int i = 0; i < CMT_W; i++) popCmt = popCmt + CMT_CW'(v[i]);
  endfunction

  // dispatchFire_i already means renameReady & backEndReady; lane bits only
  // count in a cycle where the whole bundle is accepted.
  logic [DISP_CW-1:0] dispCnt;
  logic [DISP_CW-1:0] loadCnt;
  logic [DISP_CW-1:0] storeCnt;
  logic [ISS_CW-1:0]  issCnt;
  logic [CMT_CW-1:0]  alCmtCnt;
  logic [CMT_CW-1:0]  ldCmtCnt;
  logic [CMT_CW-1:0]  stCmtCnt;

  assign dispCnt  = dispatchFire_i ? popDisp(laneValid_i) : '0;
  assign loadCnt  = dispatchFire_i ? popDisp(laneValid_i & laneIsLoad_i) : '0;
  assign storeCnt = dispatchFire_i ? popDisp(laneValid_i & laneIsStore_i) : '0;
  assign issCnt   = popIss(iqIssued_i);
  assign alCmtCnt = popCmt(alCommit_i);
  assign ldCmtCnt = popCmt(ldCommit_i);
  assign stCmtCnt = popCmt(stCommit_i);

  logic iqErr, alErr, lqErr, sqErr, stcErr;
  logic occError;

  logic [IQ_W-1:0]  unusedIqHold, unusedIqNext;
  logic [AL_W-1:0]  unusedAlHold, unusedAlNext;
  logic [LSQ_W-1:0] unusedLqHold, unusedLqNext;
  logic [LSQ_W-1:0] unusedSqNext;
  logic [LSQ_W-1:0] unusedStcHold, unusedStCommitted;
  logic [LSQ_W-1:0] sqHold;
  logic [LSQ_W-1:0] stcNext;
  logic [LSQ_W-1:0] stcLimit;

  occ_counter #(.CNT_W(IQ_W), .INC_W(DISP_CW), .DEC_W(ISS_CW)) iqCounter (
    .clk        (clk),
    .reset      (reset),
    .inc        (dispCnt),
    .dec        (issCnt),
    .limit      (IQ_MAX),
    .flush      (flush_i),
    .flushValue ('0),
    .count      (issueQueueCnt_o),
    .holdNext   (unusedIqHold),
    .nextCount  (unusedIqNext),
    .error      (iqErr)
  );

  occ_counter #(.CNT_W(AL_W), .INC_W(DISP_CW), .DEC_W(CMT_CW)) alCounter (
    .clk        (clk),
    .reset      (reset),
    .inc        (dispCnt),
    .dec        (alCmtCnt),
    .limit      (AL_MAX),
    .flush      (flush_i),
    .flushValue ('0),
    .count      (activeListCnt_o),
    .holdNext   (unusedAlHold),
    .nextCount  (unusedAlNext),
    .error      (alErr)
  );

  occ_counter #(.CNT_W(LSQ_W), .INC_W(DISP_CW), .DEC_W(CMT_CW)) lqCounter (
    .clk        (clk),
    .reset      (reset),
    .inc        (loadCnt),
    .dec        (ldCmtCnt),
    .limit      (LSQ_MAX),
    .flush      (flush_i),
    .flushValue ('0),
    .count      (loadQueueCnt_o),
    .holdNext   (unusedLqHold),
    .nextCount  (unusedLqNext),
    .error      (lqErr)
  );

  // Committed stores survive a flush, so the store queue collapses to the
  // committed-but-not-drained count instead of zero.
  occ_counter #(.CNT_W(LSQ_W), .INC_W(DISP_CW), .DEC_W(1)) sqCounter (
    .clk        (clk),
    .reset      (reset),
    .inc        (storeCnt),
    .dec        (stRetire_i),
    .limit      (LSQ_MAX),
    .flush      (flush_i),
    .flushValue (stcNext),
    .count      (storeQueueCnt_o),
    .holdNext   (sqHold),
    .nextCount  (unusedSqNext),
    .error      (sqErr)
  );

  // stCommitted is bounded by the store queue it lives in; on a flush the
  // store queue follows stCommitted, so only the structure size applies.
  assign stcLimit = flush_i ? LSQ_MAX : sqHold;

  occ_counter #(.CNT_W(LSQ_W), .INC_W(CMT_CW), .DEC_W(1)) stcCounter (
    .clk        (clk),
    .reset      (reset),
    .inc        (stCmtCnt),
    .dec        (stRetire_i),
    .limit      (stcLimit),
    .flush      (1'b0),
    .flushValue ('0),
    .count      (unusedStCommitted),
    .holdNext   (unusedStcHold),
    .nextCount  (stcNext),
    .error      (stcErr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occError <= 1'b0;
    end else if (iqErr || alErr || lqErr || sqErr || stcErr) begin
      occError <= 1'b1;
    end
  end

  assign occError_o = occError;

endmodule

// File: tb/tb_occupancy_tracker.sv
// Bench for occupancy_tracker: directed scenarios plus random traffic, all
// checked against an integer reference model through an expected queue.
module tb_occupancy_tracker;
  import occupancy_tracker_pkg::*;

  localparam int W = 27;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       dispatchFire_i = 1'b0;
  logic [3:0] laneValid_i = '0;
  logic [3:0] laneIsLoad_i = '0;
  logic [3:0] laneIsStore_i = '0;
  logic [3:0] iqIssued_i = '0;
  logic [3:0] alCommit_i = '0;
  logic [3:0] ldCommit_i = '0;
  logic [3:0] stCommit_i = '0;
  logic       stRetire_i = 1'b0;
  logic       flush_i = 1'b0;
  logic [5:0] issueQueueCnt_o;
  logic [7:0] activeListCnt_o;
  logic [5:0] loadQueueCnt_o;
  logic [5:0] storeQueueCnt_o;
  logic       occError_o;

  always #5 clk = ~clk;

  occupancy_tracker dut (
    .clk             (clk),
    .reset           (reset),
    .dispatchFire_i  (dispatchFire_i),
    .laneValid_i     (laneValid_i),
    .laneIsLoad_i    (laneIsLoad_i),
    .laneIsStore_i   (laneIsStore_i),
    .iqIssued_i      (iqIssued_i),
    .alCommit_i      (alCommit_i),
    .ldCommit_i      (ldCommit_i),
    .stCommit_i      (stCommit_i),
    .stRetire_i      (stRetire_i),
    .flush_i         (flush_i),
    .issueQueueCnt_o (issueQueueCnt_o),
    .activeListCnt_o (activeListCnt_o),
    .loadQueueCnt_o  (loadQueueCnt_o),
    .storeQueueCnt_o (storeQueueCnt_o),
    .occError_o      (occError_o)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  int mIq, mAl, mLq, mSq, mStc;
  bit mErr;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic bound(input int v, input int hi);
    if (v < 0 || v > hi) mErr = 1'b1;
  endtask

  // Reference: each structure is an integer occupancy; a cycle adds what was
  // dispatched, removes what left, and saturates (flagging) outside [0, size].
  task automatic modelStep(input logic rst, input logic fire,
                           input logic [3:0] valid, ld, st, iss, alc, ldc, stc,
                           input logic ret, input logic fl);
    int dispN, sqRaw, sqSat, stcRaw, lim, iqRaw, alRaw, lqRaw;
    if (!rst) begin
      mIq = 0; mAl = 0; mLq = 0; mSq = 0; mStc = 0; mErr = 1'b0;
      return;
    end
    dispN  = fire ? $countones(valid) : 0;
    sqRaw  = mSq + (fire ? $countones(valid & st) : 0) - int'(ret);
    sqSat  = sat(sqRaw, SIZE_LSQ);
    stcRaw = mStc + $countones(stc) - int'(ret);
    lim    = fl ? SIZE_LSQ : sqSat;
    bound(stcRaw, lim);
    mStc = sat(stcRaw, lim);
    if (fl) begin
      mIq = 0; mAl = 0; mLq = 0; mSq = mStc;
    end else begin
      iqRaw = mIq + dispN - $countones(iss);
      alRaw = mAl + dispN - $countones(alc);
      lqRaw = mLq + (fire ? $countones(valid & ld) : 0) - $countones(ldc);
      bound(iqRaw, SIZE_ISSUEQ);
      bound(alRaw, SIZE_ACTIVELIST);
      bound(lqRaw, SIZE_LSQ);
      bound(sqRaw, SIZE_LSQ);
      mIq = sat(iqRaw, SIZE_ISSUEQ);
      mAl = sat(alRaw, SIZE_ACTIVELIST);
      mLq = sat(lqRaw, SIZE_LSQ);
      mSq = sqSat;
    end
  endtask

  task automatic step(input logic rst, input logic fire,
                      input logic [3:0] valid, ld, st, iss, alc, ldc, stc,
                      input logic ret, input logic fl);
    @(negedge clk);
    #1;
    reset = rst; dispatchFire_i = fire; laneValid_i = valid;
    laneIsLoad_i = ld; laneIsStore_i = st; iqIssued_i = iss;
    alCommit_i = alc; ldCommit_i = ldc; stCommit_i = stc;
    stRetire_i = ret; flush_i = fl;
    modelStep(rst, fire, valid, ld, st, iss, alc, ldc, stc, ret, fl);
    exp_q.push_back({6'(mIq), 8'(mAl), 6'(mLq), 6'(mSq), mErr});
  endtask

  task automatic idle(input logic rst);
    step(rst, 1'b0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic afterEdge();
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are valid every cycle, one expected entry per cycle.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("mon_iq",  int'(issueQueueCnt_o), int'(e[26:21]));
      chk("mon_al",  int'(activeListCnt_o), int'(e[20:13]));
      chk("mon_lq",  int'(loadQueueCnt_o),  int'(e[12:7]));
      chk("mon_sq",  int'(storeQueueCnt_o), int'(e[6:1]));
      chk("mon_err", int'(occError_o),      int'(e[0]));
    end
  end

  initial begin
    logic [3:0] ld, st, iss, alc, ldc, stc;
    logic       rst;
    int         kind;

    mIq = 0; mAl = 0; mLq = 0; mSq = 0; mStc = 0; mErr = 1'b0;

    // Reset, then release: everything starts at zero.
    idle(1'b0);
    idle(1'b0);
    idle(1'b1);
    afterEdge();
    chk("rel_iq",  int'(issueQueueCnt_o), 0);
    chk("rel_al",  int'(activeListCnt_o), 0);
    chk("rel_err", int'(occError_o), 0);

    // Three 4-wide dispatches (2 loads, 1 store each), then two issues.
    repeat (3) step(1'b1, 1'b1, 4'b1111, 4'b0011, 4'b0100, '0, '0, '0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, '0, '0, 4'b0011, '0, '0, '0, 1'b0, 1'b0);
    afterEdge();
    chk("disp_iq", int'(issueQueueCnt_o), 10);
    chk("disp_al", int'(activeListCnt_o), 12);
    chk("disp_lq", int'(loadQueueCnt_o), 6);
    chk("disp_sq", int'(storeQueueCnt_o), 3);

    // Flush with same-cycle store commits keeps the committed stores.
    idle(1'b0);
    step(1'b1, 1'b1, 4'b1111, '0, 4'b1111, '0, '0, '0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'b0001, '0, 4'b0001, '0, '0, '0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, '0, '0, 4'b1111, 4'b1111, '0, 4'b0011, 1'b0, 1'b1);
    afterEdge();
    chk("flush_iq", int'(issueQueueCnt_o), 0);
    chk("flush_al", int'(activeListCnt_o), 0);
    chk("flush_lq", int'(loadQueueCnt_o), 0);
    chk("flush_sq", int'(storeQueueCnt_o), 2);
    step(1'b1, 1'b0, '0, '0, '0, '0, '0, '0, '0, 1'b1, 1'b0);
    afterEdge();
    chk("retire_sq",  int'(storeQueueCnt_o), 1);
    chk("retire_err", int'(occError_o), 0);

    // Active-list underflow.
    idle(1'b0);
    step(1'b1, 1'b1, 4'b0011, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, '0, '0, '0, 4'b0111, '0, '0, 1'b0, 1'b0);
    afterEdge();
    chk("under_al",  int'(activeListCnt_o), 0);
    chk("under_err", int'(occError_o), 1);

    // Committed stores cannot exceed an empty store queue.
    idle(1'b0);
    step(1'b1, 1'b0, '0, '0, '0, '0, '0, '0, 4'b0001, 1'b0, 1'b0);
    afterEdge();
    chk("stc_err", int'(occError_o), 1);

    // Issue-queue overflow to exactly the size, sticky error.
    idle(1'b0);
    repeat (7) step(1'b1, 1'b1, 4'b1111, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'b0011, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'b1111, '0, '0, 4'b0001, '0, '0, '0, 1'b0, 1'b0);
    afterEdge();
    chk("over_iq",  int'(issueQueueCnt_o), 32);
    chk("over_err", int'(occError_o), 1);
    idle(1'b1);
    idle(1'b1);
    afterEdge();
    chk("sticky_err", int'(occError_o), 1);

    // Asynchronous reset between edges clears outputs at once.
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_iq",  int'(issueQueueCnt_o), 0);
    chk("async_al",  int'(activeListCnt_o), 0);
    chk("async_err", int'(occError_o), 0);
    modelStep(1'b0, 1'b0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);

    // Random traffic with occasional flushes and resets.
    for (int n = 0; n < 1500; n++) begin
      ld = '0; st = '0;
      for (int l = 0; l < 4; l++) begin
        kind = $urandom_range(0, 3);
        ld[l] = (kind == 0);
        st[l] = (kind == 1);
      end
      iss = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      alc = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      ldc = ($urandom_range(0, 2) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
      stc = ($urandom_range(0, 2) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
      rst = ($urandom_range(0, 99) != 0);
      step(rst, ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), ld, st,
           iss, alc, ldc, stc, ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 19) == 0));
    end
    idle(1'b1);

    repeat (2) @(negedge clk);
    #1;
    chk("queue_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
